// File: rtl/mult_pipe_hs_wrapper.sv
// WIDTH x WIDTH multiplier with operand register, STAGES-deep product
// pipeline, per-beat signed/unsigned mode, pass-through tag and a
// valid/ready handshake with global stall.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operand beat handshake
//   in_signed                1 = two's-complement, 0 = unsigned
//   multiplicand, multiplier operands A and B (WIDTH bits)
//   in_tag                   user tag travelling with the beat
//   out_valid / out_ready    result beat handshake
//   product                  2*WIDTH-bit registered result
//   out_tag                  tag of the result beat
module mult_pipe_hs_wrapper #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int PW = 2 * WIDTH;

    logic adv;

    // stage 0: operand register
    logic             v0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             s0;
    logic [TAG_W-1:0] t0;

    // stages 1..STAGES: product, tag, valid
    logic [STAGES:1]  vp;
    logic [PW-1:0]    pp [1:STAGES];
    logic [TAG_W-1:0] tp [1:STAGES];

    logic [PW-1:0] ext_a;
    logic [PW-1:0] ext_b;
    logic [PW-1:0] mul;

    // The low 2*WIDTH bits of the extended product are the exact result
    // in both modes, so one unsigned multiplier serves signed beats too.
    always_comb begin
        ext_a = s0 ? {{WIDTH{a0[WIDTH-1]}}, a0} : {{WIDTH{1'b0}}, a0};
        ext_b = s0 ? {{WIDTH{b0[WIDTH-1]}}, b0} : {{WIDTH{1'b0}}, b0};
        mul   = ext_a * ext_b;
    end

    // The whole pipe moves as one; a held result freezes every stage.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = vp[STAGES];
    assign product   = pp[STAGES];
    assign out_tag   = tp[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            v0 <= 1'b0;
            a0 <= '0;
            b0 <= '0;
            s0 <= 1'b0;
            t0 <= '0;
            vp <= '0;
            for (int i = 1; i <= STAGES; i++) begin
                pp[i] <= '0;
                tp[i] <= '0;
            end
        end else if (adv) begin
            v0    <= in_valid;
            a0    <= multiplicand;
            b0    <= multiplier;
            s0    <= in_signed;
            t0    <= in_tag;
            vp[1] <= v0;
            pp[1] <= mul;
            tp[1] <= t0;
            for (int i = 2; i <= STAGES; i++) begin
                vp[i] <= vp[i-1];
                pp[i] <= pp[i-1];
                tp[i] <= tp[i-1];
            end
        end
    end

endmodule

// File: doc/mult_pipe_hs_wrapper.md
Name: mult_pipe_hs_wrapper

Overview:
- Parametrised successor to the fixed 8x8 register-in/register-out multiplier wrapper.
- Wraps a WIDTH x WIDTH multiplier core with a configurable-depth output pipeline, a per-transaction signed/unsigned mode and a valid/ready handshake with global stall.
- Carries a user tag alongside each operation.
- Used as the timing/PPA harness and as a reusable arithmetic unit in datapaths that need backpressure.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product width is 2*WIDTH.
- STAGES, 2, number of product pipeline registers after the operand register (>=1).
- TAG_W, 4, width of the pass-through tag (>=1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- in_signed  input  1  1 = two's-complement multiply, 0 = unsigned.
- multiplicand  input  WIDTH  operand A.
- multiplier  input  WIDTH  operand B.
- in_tag  input  TAG_W  user tag, returned with the result.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts the result.
- product  output  2*WIDTH  registered result.
- out_tag  output  TAG_W  tag of the result beat.

Behaviour:
- Reset and clock: synchronous, active-high reset on clk.
- Pipeline structure:
  - Stage 0 holds the operand register (A, B, mode, tag, valid).
  - Stages 1..STAGES hold product, tag and valid.
  - The combinational multiply sits between stage 0 and stage 1; stages 2..STAGES are pure delay.
- Reset values: all valid bits, product, out_tag and the stage-0 registers clear to 0, so out_valid=0 and product=0 after reset. in_ready=1 in the first cycle after reset is released.
- Advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational from out_valid/out_ready only; never from in_valid).
- On an edge with adv=1, every stage shifts one position:
  - Stage 0 loads {in_valid, operands, in_signed, in_tag}.
  - A cycle with in_valid=0 inserts a bubble (valid=0). Bubbles propagate like data; there is no bubble collapsing.
- On an edge with adv=0, every register holds. product and out_tag stay stable while out_valid=1 and out_ready=0.
- Handshakes:
  - Accept: in_valid && in_ready on an edge.
  - Deliver: out_valid && out_ready on an edge.
- Latency: a beat accepted on edge k drives out_valid=1 after edge k+STAGES when no stall occurs. Every stalled edge adds exactly one cycle.
- Throughput: one beat per cycle while out_ready=1.
- Ordering: results leave in acceptance order. out_tag always equals the in_tag of the same beat.
- Arithmetic:
  - in_signed=1: both operands are sign-extended to 2*WIDTH and multiplied; the result is the full two's-complement product. The most-negative squared case fits and does not overflow.
  - in_signed=0: both operands are zero-extended.
  - Mode is per-beat; mixed modes may be back-to-back.
- Simultaneous events: with the pipeline full, out_ready=1 and in_valid=1 on the same edge, one result leaves and one operand enters on that edge.
- Reset mid-operation: rst=1 on any edge clears all valid bits and data registers regardless of stall state. In-flight beats are discarded with no output pulse. rst has priority over adv.
- out_valid is never X after reset. Inputs are ignored when in_ready=0.

Test Plan:
- Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, product=0x0000, in_ready=1 after release; no output beat appears.
- Latency (WIDTH=8, STAGES=2), unsigned 255*255, out_ready=1, accept at edge k -> out_valid=1 after edge k+2 with product=0xFE01 for exactly one cycle.
- Signed corners, back-to-back, tags 1..3:
  - -128*-128 -> 0x4000, tag 1.
  - -128*127 -> 0xC080, tag 2.
  - -1*-1 -> 0x0001, tag 3.
  - Same values unsigned: 0x80*0x80 -> 0x4000; 0xFF*0xFF -> 0xFE01.
  - Results arrive on consecutive cycles.
- Backpressure: stream 6 beats, drop out_ready for 4 cycles mid-stream -> in_ready=0 while out_valid=1; product and tag held stable; no loss or duplication; all 6 results in order.
- Simultaneous accept/deliver: full pipeline, out_ready=1 and in_valid=1 for 10 cycles -> exactly 10 accepts and 10 deliveries; occupancy constant.
- Mid-flight reset: accept 2 beats, assert rst for 1 cycle before the first emerges -> no out_valid pulse for either; next beat accepted afterwards emerges with the nominal latency.
